// File: rtl/pong_scan_render.sv
// Row-scanned renderer for a WIDTH x WIDTH pong matrix: four edge paddles, lit corners and a ball,
// presented one registered row at a time, with paddle-neighbourhood flags around the ball.
module pong_scan_render #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int SIZE         = 2,
  parameter int SCAN_DIV     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [BIT_OF_WIDTH-1:0]   player_top,
  input  logic [BIT_OF_WIDTH-1:0]   player_down,
  input  logic [BIT_OF_WIDTH-1:0]   player_left,
  input  logic [BIT_OF_WIDTH-1:0]   player_right,
  input  logic [2*BIT_OF_WIDTH-1:0] pos_ball,
  output logic [WIDTH-1:0]          row_data,
  output logic [BIT_OF_WIDTH-1:0]   row_sel,
  output logic                      frame_start,
  output logic [2:0]                near_top,
  output logic [2:0]                near_down,
  output logic [2:0]                near_left,
  output logic [2:0]                near_right
);

  localparam int B  = BIT_OF_WIDTH;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic [B-1:0] top;
    logic [B-1:0] down;
    logic [B-1:0] left;
    logic [B-1:0] right;
    logic [B-1:0] bx;
    logic [B-1:0] by;
  } snap_t;

  state_t        state, state_next;
  snap_t         snap, live, src;
  logic [PW-1:0] presc;
  logic          running;
  logic          wrap, new_frame, advance;
  logic [B-1:0]  row_next;
  logic [WIDTH-1:0] row_data_next;
  logic [2:0]    near_top_next, near_down_next, near_left_next, near_right_next;
  int            bx_i, by_i;

  function automatic int clamp(input logic [B-1:0] p);
    int v;
    v = int'(p);
    return (v > WIDTH - SIZE) ? WIDTH - SIZE : v;
  endfunction

  function automatic logic in_paddle(input int i, input logic [B-1:0] p);
    return (i >= clamp(p)) && (i < clamp(p) + SIZE);
  endfunction

  // Border pixel (paddles and corners, no ball); anything off the matrix reads dark.
  function automatic logic border_px(input int r, input int c, input snap_t s);
    logic px;
    if (r < 0 || r >= WIDTH || c < 0 || c >= WIDTH) return 1'b0;
    px = 1'b0;
    if (r == 0 && in_paddle(c, s.top)) px = 1'b1;
    if (r == WIDTH - 1 && in_paddle(c, s.down)) px = 1'b1;
    if (c == 0 && in_paddle(r, s.left)) px = 1'b1;
    if (c == WIDTH - 1 && in_paddle(r, s.right)) px = 1'b1;
    if ((r == 0 || r == WIDTH - 1) && (c == 0 || c == WIDTH - 1)) px = 1'b1;
    return px;
  endfunction

  function automatic logic [WIDTH-1:0] render_row(input int r, input snap_t s);
    logic [WIDTH-1:0] row;
    for (int c = 0; c < WIDTH; c++)
      row[c] = border_px(r, c, s) | ((int'(s.bx) == c) && (int'(s.by) == r));
    return row;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = SCAN;
      SCAN:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new frame starts either on the first scanning cycle or when the last row wraps.
  always_comb begin
    live      = '{top: player_top, down: player_down, left: player_left,
                  right: player_right, bx: pos_ball[2*B-1:B], by: pos_ball[B-1:0]};
    wrap      = (presc == PW'(SCAN_DIV - 1));
    new_frame = (state == SCAN) && enable &&
                (!running || (wrap && (int'(row_sel) == WIDTH - 1)));
    advance   = (state == SCAN) && enable && (!running || wrap);
    src       = new_frame ? live : snap;
    row_next  = new_frame ? '0 : row_sel + 1'b1;
    row_data_next = render_row(int'(row_next), src);
    bx_i = int'(src.bx);
    by_i = int'(src.by);
    near_top_next   = (by_i == 1) ?
      {border_px(0, bx_i + 1, src), border_px(0, bx_i, src), border_px(0, bx_i - 1, src)} : 3'b0;
    near_down_next  = (by_i == WIDTH - 2) ?
      {border_px(WIDTH - 1, bx_i + 1, src), border_px(WIDTH - 1, bx_i, src),
       border_px(WIDTH - 1, bx_i - 1, src)} : 3'b0;
    near_left_next  = (bx_i == 1) ?
      {border_px(by_i + 1, 0, src), border_px(by_i, 0, src), border_px(by_i - 1, 0, src)} : 3'b0;
    near_right_next = (bx_i == WIDTH - 2) ?
      {border_px(by_i + 1, WIDTH - 1, src), border_px(by_i, WIDTH - 1, src),
       border_px(by_i - 1, WIDTH - 1, src)} : 3'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running     <= 1'b0;
      presc       <= '0;
      row_sel     <= '0;
      row_data    <= '0;
      frame_start <= 1'b0;
      snap        <= '0;
      near_top    <= '0;
      near_down   <= '0;
      near_left   <= '0;
      near_right  <= '0;
    end else if (state == SCAN && enable) begin
      running     <= 1'b1;
      frame_start <= new_frame;
      if (advance) begin
        presc    <= '0;
        row_sel  <= row_next;
        row_data <= row_data_next;
      end else begin
        presc <= presc + 1'b1;
      end
      if (new_frame) begin
        snap       <= live;
        near_top   <= near_top_next;
        near_down  <= near_down_next;
        near_left  <= near_left_next;
        near_right <= near_right_next;
      end
    end else begin
      running     <= 1'b0;
      presc       <= '0;
      row_sel     <= '0;
      row_data    <= '0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pong_scan_render.sv
// Bench for pong_scan_render: frame-level reference model (cycle index -> row, snapshot board)
// driven by directed scenarios and randomized inputs.
module tb_pong_scan_render;

  localparam int W  = 8;
  localparam int B  = 3;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int FR = W * D;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [B-1:0] player_top = '0, player_down = '0, player_left = '0, player_right = '0;
  logic [2*B-1:0] pos_ball = '0;
  logic [W-1:0] row_data;
  logic [B-1:0] row_sel;
  logic         frame_start;
  logic [2:0]   near_top, near_down, near_left, near_right;

  int tests = 0;
  int errors = 0;

  pong_scan_render #(.WIDTH(W), .BIT_OF_WIDTH(B), .SIZE(S), .SCAN_DIV(D)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .player_top(player_top), .player_down(player_down),
    .player_left(player_left), .player_right(player_right),
    .pos_ball(pos_ball), .row_data(row_data), .row_sel(row_sel),
    .frame_start(frame_start), .near_top(near_top), .near_down(near_down),
    .near_left(near_left), .near_right(near_right)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_scan = 0;
  int         m_k = -1;
  int         s_top, s_down, s_left, s_right, s_bx, s_by;
  bit         board[W][W];
  logic [W-1:0] m_row = '0;
  logic [B-1:0] m_sel = '0;
  logic       m_fs = 1'b0;
  logic [2:0] m_nt = '0, m_nd = '0, m_nl = '0, m_nr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lim(input int p);
    return (p < W - S) ? p : W - S;
  endfunction

  function automatic bit bpx(input int r, input int c);
    if (r < 0 || r >= W || c < 0 || c >= W) return 1'b0;
    return board[r][c];
  endfunction

  task automatic build_board();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) board[r][c] = 1'b0;
    for (int i = 0; i < S; i++) begin
      board[0][lim(s_top) + i]       = 1'b1;
      board[W-1][lim(s_down) + i]    = 1'b1;
      board[lim(s_left) + i][0]      = 1'b1;
      board[lim(s_right) + i][W-1]   = 1'b1;
    end
    board[0][0] = 1'b1; board[0][W-1] = 1'b1;
    board[W-1][0] = 1'b1; board[W-1][W-1] = 1'b1;
  endtask

  task automatic model_reset();
    m_scan = 0; m_k = -1;
    s_top = 0; s_down = 0; s_left = 0; s_right = 0; s_bx = 0; s_by = 0;
    m_row = '0; m_sel = '0; m_fs = 1'b0;
    m_nt = '0; m_nd = '0; m_nl = '0; m_nr = '0;
  endtask

  task automatic model_edge();
    int row;
    if (reset) begin
      model_reset();
    end else if (!m_scan) begin
      if (enable) begin m_scan = 1; m_k = -1; end
    end else if (!enable) begin
      m_scan = 0; m_row = '0; m_sel = '0; m_fs = 1'b0;
    end else begin
      m_k++;
      m_fs = ((m_k % FR) == 0);
      if (m_fs) begin
        s_top = int'(player_top); s_down = int'(player_down);
        s_left = int'(player_left); s_right = int'(player_right);
        s_bx = int'(pos_ball[2*B-1:B]); s_by = int'(pos_ball[B-1:0]);
        build_board();
        m_nt = (s_by == 1)     ? {bpx(0, s_bx+1), bpx(0, s_bx), bpx(0, s_bx-1)} : 3'b0;
        m_nd = (s_by == W - 2) ? {bpx(W-1, s_bx+1), bpx(W-1, s_bx), bpx(W-1, s_bx-1)} : 3'b0;
        m_nl = (s_bx == 1)     ? {bpx(s_by+1, 0), bpx(s_by, 0), bpx(s_by-1, 0)} : 3'b0;
        m_nr = (s_bx == W - 2) ? {bpx(s_by+1, W-1), bpx(s_by, W-1), bpx(s_by-1, W-1)} : 3'b0;
      end
      row = (m_k / D) % W;
      m_sel = B'(row);
      for (int c = 0; c < W; c++) m_row[c] = board[row][c] | (s_by == row && s_bx == c);
    end
  endtask

  task automatic compare_all();
    check("row_data", row_data, m_row);
    check("row_sel", row_sel, m_sel);
    check("frame_start", frame_start, m_fs);
    check("near_top", near_top, m_nt);
    check("near_down", near_down, m_nd);
    check("near_left", near_left, m_nl);
    check("near_right", near_right, m_nr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to_frame();
    for (int i = 0; i < FR + 4; i++) begin
      step();
      if (m_fs) break;
    end
    check("frame_seen", m_fs, 1'b1);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_row", row_data, '0);
    check("async_rst_sel", row_sel, '0);
    check("async_rst_near", {near_top, near_down, near_left, near_right}, '0);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("reset_row", row_data, '0);
    check("reset_fs", frame_start, 1'b0);
    check("reset_near", {near_top, near_down, near_left, near_right}, '0);
    step(); step();
    reset = 1'b0;

    // Baseline frame: players at 0, ball at (4,4)
    enable = 1'b1;
    pos_ball = {3'd4, 3'd4};
    step();
    check("entry_blank", row_data, '0);
    step();
    check("first_row0", row_data, 8'b1000_0011);
    check("first_fs", frame_start, 1'b1);
    for (int i = 0; i < FR; i++) step();
    check("fs_period", frame_start, 1'b1);

    // Clamped top and down paddles
    player_top = 3'd7;
    player_down = 3'd6;
    run_to_frame();
    check("clamp_top_row0", row_data, 8'b1100_0001);
    for (int i = 0; i < 28; i++) step();
    check("down_row7_sel", row_sel, 3'd7);
    check("down_row7", row_data, 8'b1100_0001);

    // Ball next to the top paddle
    player_top = 3'd3; player_down = 3'd0;
    pos_ball = {3'd4, 3'd1};
    run_to_frame();
    check("near_top_011", near_top, 3'b011);
    for (int i = 0; i < FR - 1; i++) step();
    check("near_top_held", near_top, 3'b011);

    // Ball in the top-left pocket
    player_top = 3'd0; player_left = 3'd0;
    pos_ball = {3'd1, 3'd1};
    run_to_frame();
    check("near_left_011", near_left, 3'b011);
    check("near_top_bit0", near_top[0], 1'b1);

    // Mid-frame ball move is not shown until the next frame
    for (int i = 0; i < 6; i++) step();
    pos_ball = {3'd5, 3'd3};
    for (int i = 0; i < 10; i++) step();
    run_to_frame();

    // Enable dropped at row 3, restored five cycles later
    for (int i = 0; i < FR; i++) begin
      if (m_sel == 3'd3) break;
      step();
    end
    enable = 1'b0;
    step();
    check("drop_blank", row_data, '0);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b1;
    step();
    check("reenable_blank", row_data, '0);
    step();
    check("reenable_fs", frame_start, 1'b1);
    check("reenable_sel", row_sel, 3'd0);

    // Asynchronous reset in the middle of a row
    for (int i = 0; i < 6; i++) step();
    async_reset();
    step();
    reset = 1'b0;
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) player_top   = B'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) player_down  = B'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) player_left  = B'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) player_right = B'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pos_ball     = (2*B)'($urandom_range(0, 63));
      if (enable) begin
        if ($urandom_range(0, 79) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
